scan_frame_builder: RTL
=======================

Name: scan_frame_builder

Overview:
- Upstream producer for the Ethernet packet former.
- Accepts a stream of 16-bit conditioned-channel samples and writes them into the scan SRAM starting at address 0.
- Each scan is prefixed with a 4-word header. Once SCANS_PER_PACKET scans are stored, the block asserts packet_formed and locks the SRAM until the packet former has finished reading it.
- Runs entirely in the clk_i domain shared with the packet former.

Parameters:
- SCAN_WORDS, 52, 16-bit words per scan including header (104 bytes).
- HDR_WORDS, 4, header words at the start of each scan.
- SCANS_PER_PACKET, 1, scans per publication; must be >= 1.
- ADDR_W, 20, SRAM word-address width.
- SYNC_WORD, 16'hA55A, header word 0.

Ports:
- clk_i  in  1  system clock, same as the packet former clk_i.
- rst_ni  in  1  asynchronous active-low reset.
- sample_valid  in  1  sample_data is valid this cycle.
- sample_data  in  16  conditioned sample, written verbatim.
- sample_ready  out  1  block accepts the sample this cycle.
- sram_wr_addr  out  ADDR_W  SRAM write word address.
- sram_wr_data  out  16  SRAM write data.
- sram_we  out  1  SRAM write strobe, one word per cycle.
- packet_formed  out  1  level request to the packet former.
- eth_forming_packet  in  1  packet former busy; it reads the SRAM while high.
- num_scans  out  32  constant SCANS_PER_PACKET, zero-extended.
- seq_num  out  16  sequence number of the last published packet.
- busy  out  1  high while not in IDLE.

Behaviour:
- Reset (async assert on rst_ni low, sync release) drives: state IDLE; sample_ready=0, sram_we=0, sram_wr_addr=0, sram_wr_data=0, packet_formed=0, seq_num=0, busy=0; internal counters 0; 32-bit timestamp counter = 0.
- Timestamp counter is free-running and increments every cycle, wrapping modulo 2^32.
- A sample transfer occurs when sample_valid && sample_ready. sample_ready is a registered output and is high only in COLLECT.
- States and transitions:
  - IDLE: one cycle; clears word_cnt, scan_cnt and wr_ptr; goes to HEADER.
  - HEADER: four cycles with sram_we=1, writing at wr_ptr..wr_ptr+3 in order:
    - word 0 = SYNC_WORD;
    - word 1 = scan sequence number (increments per scan, wraps at 16'hFFFF -> 0);
    - word 2 = timestamp[31:16];
    - word 3 = timestamp[15:0].
    - The timestamp is latched on the first HEADER cycle.
    - Then goes to COLLECT.
  - COLLECT: each transfer writes sample_data at wr_ptr the same cycle (sram_we=1) and increments wr_ptr and word_cnt. After SCAN_WORDS-HDR_WORDS (48) samples:
    - if scan_cnt+1 < SCANS_PER_PACKET, go to HEADER with scan_cnt incremented;
    - otherwise go to PUBLISH.
    - Idle cycles with no valid input neither write nor advance.
  - PUBLISH: packet_formed=1 and held; waits for eth_forming_packet=1, then goes to WAIT_DONE. packet_formed drops on that transition.
  - WAIT_DONE: SRAM locked and sample_ready=0; when eth_forming_packet=0, seq_num <= seq_num+1 and go to IDLE.
- Latency: the SRAM write is registered, so the word appears on sram_wr_* one cycle after acceptance.
- Address rule: wr_ptr never exceeds SCAN_WORDS*SCANS_PER_PACKET-1; every publication starts at address 0, matching the packet former reading from 0.
- Backpressure: while sample_ready=0 (HEADER, PUBLISH, WAIT_DONE, IDLE) upstream must hold data. No samples are ever dropped internally.
- Boundary conditions:
  - sample_valid arriving in the last COLLECT cycle of a scan: ready deasserts on the next cycle; no 49th write.
  - eth_forming_packet already high when entering PUBLISH (stale busy from a prior transfer): treated as the ack.
  - Reset mid-scan: the partially written SRAM is abandoned. packet_formed is never asserted for a partial scan.
  - seq_num wraps 16'hFFFF -> 0.

Decomposition:
- Package scan_frame_pkg holds:
  - the state enum (IDLE, HEADER, COLLECT, PUBLISH, WAIT_DONE);
  - constants SYNC_WORD, HDR_WORDS and SCAN_WORDS;
  - a header-word index typedef.
- One sub-module is natural: scan_header_gen (timestamp counter, latch and 4-word header mux selected by index).

Test Plan:
- Reset release, 48 samples 16'h0001..16'h0030 with continuous valid -> SRAM words 0..3 = A55A, 0000, ts_hi, ts_lo; words 4..51 = 0001..0030; packet_formed rises one cycle after the last write.
- Hold eth_forming_packet low for 20 cycles in PUBLISH -> packet_formed stays 1 and sample_ready stays 0; raise it -> packet_formed falls next cycle.
- Drop eth_forming_packet after 60 cycles -> seq_num=1; next header word 0 is written at address 0 and header word 1 = 0001.
- SCANS_PER_PACKET=3, 144 samples -> headers at addresses 0, 52 and 104; last write at address 155; num_scans=3; single packet_formed.
- sample_valid toggling 1-0-1 with random gaps -> exactly 48 writes per scan, no duplicates, and the addresses are contiguous.
- Assert rst_ni low after 20 samples -> all outputs return to reset values immediately; after release, the next scan starts at address 0 with sequence number 0.

Source files
------------

// File: rtl/scan_frame_pkg.sv
// Shared types and constants for the scan frame builder: FSM states,
// header layout and the header-word selector.
package scan_frame_pkg;

   localparam logic [15:0] SYNC_WORD  = 16'hA55A;
   localparam int          HDR_WORDS  = 4;
   localparam int          SCAN_WORDS = 52;

   typedef enum logic [2:0] {
      IDLE,
      HEADER,
      COLLECT,
      PUBLISH,
      WAIT_DONE
   } state_t;

   typedef logic [1:0] hdr_idx_t;

   // Header layout: sync, scan sequence, timestamp high, timestamp low.
   function automatic logic [15:0] hdr_word(input hdr_idx_t    idx,
                                            input logic [15:0] sync,
                                            input logic [15:0] seq,
                                            input logic [31:0] ts);
      case (idx)
         2'd0:    return sync;
         2'd1:    return seq;
         2'd2:    return ts[31:16];
         default: return ts[15:0];
      endcase
   endfunction

endpackage

// File: rtl/scan_header_gen.sv
// Free-running timestamp, per-scan timestamp latch and the 4-word header mux.
module scan_header_gen #(
   parameter logic [15:0] SYNC_WORD = scan_frame_pkg::SYNC_WORD
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     i_latch,
   input  scan_frame_pkg::hdr_idx_t i_idx,
   input  logic [15:0]              i_seq,
   output logic [15:0]              o_word
);
   import scan_frame_pkg::*;

   logic [31:0] r_ts;
   logic [31:0] r_ts_lat;
   logic [15:0] w_words [HDR_WORDS];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ts     <= '0;
         r_ts_lat <= '0;
      end else begin
         r_ts <= r_ts + 1'b1;
         if (i_latch) begin
            r_ts_lat <= r_ts;
         end
      end
   end

   // The latch happens on word 0, so words 2/3 always see this scan's stamp.
   genvar gi;
   generate
      for (gi = 0; gi < HDR_WORDS; gi++) begin : g_word
         assign w_words[gi] = hdr_word(hdr_idx_t'(gi), SYNC_WORD, i_seq, r_ts_lat);
      end
   endgenerate

   assign o_word = w_words[i_idx];

endmodule

// File: rtl/scan_frame_builder.sv
// Builds header-prefixed scans in the scan SRAM from the sample stream and
// publishes them to the packet former once a full packet is stored.
module scan_frame_builder #(
   parameter int          SCAN_WORDS       = scan_frame_pkg::SCAN_WORDS,
   parameter int          HDR_WORDS        = scan_frame_pkg::HDR_WORDS,
   parameter int          SCANS_PER_PACKET = 1,
   parameter int          ADDR_W           = 20,
   parameter logic [15:0] SYNC_WORD        = scan_frame_pkg::SYNC_WORD
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              sample_valid,
   input  logic [15:0]       sample_data,
   output logic              sample_ready,
   output logic [ADDR_W-1:0] sram_wr_addr,
   output logic [15:0]       sram_wr_data,
   output logic              sram_we,
   output logic              packet_formed,
   input  logic              eth_forming_packet,
   output logic [31:0]       num_scans,
   output logic [15:0]       seq_num,
   output logic              busy
);
   import scan_frame_pkg::*;

   localparam int SAMPLES = SCAN_WORDS - HDR_WORDS;
   localparam int CNT_W   = $clog2(SAMPLES);
   localparam int SCAN_W  = (SCANS_PER_PACKET > 1) ? $clog2(SCANS_PER_PACKET) : 1;

   localparam logic [CNT_W-1:0]  LAST_SAMPLE = CNT_W'(SAMPLES - 1);
   localparam logic [SCAN_W-1:0] LAST_SCAN   = SCAN_W'(SCANS_PER_PACKET - 1);
   localparam hdr_idx_t          LAST_HDR    = hdr_idx_t'(HDR_WORDS - 1);

   state_t            r_state;
   state_t            w_state_next;
   logic [CNT_W-1:0]  r_word_cnt;
   logic [SCAN_W-1:0] r_scan_cnt;
   logic [ADDR_W-1:0] r_wr_ptr;
   hdr_idx_t          r_hdr_idx;
   logic [15:0]       r_scan_seq;
   logic [15:0]       r_seq_num;
   logic              r_ready;
   logic              r_we;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [15:0]       r_wr_data;
   logic              r_packet_formed;

   logic              w_xfer;
   logic              w_scan_done;
   logic              w_hdr_done;
   logic              w_ts_latch;
   logic [15:0]       w_hdr_word;

   assign w_xfer      = sample_valid && r_ready;
   assign w_scan_done = w_xfer && (r_word_cnt == LAST_SAMPLE);
   assign w_hdr_done  = (r_hdr_idx == LAST_HDR);
   assign w_ts_latch  = (r_state == HEADER) && (r_hdr_idx == '0);

   scan_header_gen #(
      .SYNC_WORD (SYNC_WORD)
   ) u_header_gen (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_latch (w_ts_latch),
      .i_idx   (r_hdr_idx),
      .i_seq   (r_scan_seq),
      .o_word  (w_hdr_word)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:      w_state_next = HEADER;
         HEADER:    if (w_hdr_done) w_state_next = COLLECT;
         COLLECT:   if (w_scan_done) w_state_next = (r_scan_cnt == LAST_SCAN) ? PUBLISH : HEADER;
         PUBLISH:   if (eth_forming_packet) w_state_next = WAIT_DONE;
         WAIT_DONE: if (!eth_forming_packet) w_state_next = IDLE;
         default:   w_state_next = IDLE;
      endcase
   end

   // Ready and packet_formed are registered from the next state so they line
   // up exactly with the state they describe.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_word_cnt      <= '0;
         r_scan_cnt      <= '0;
         r_wr_ptr        <= '0;
         r_hdr_idx       <= '0;
         r_scan_seq      <= '0;
         r_seq_num       <= '0;
         r_ready         <= 1'b0;
         r_we            <= 1'b0;
         r_wr_addr       <= '0;
         r_wr_data       <= '0;
         r_packet_formed <= 1'b0;
      end else begin
         r_ready         <= (w_state_next == COLLECT);
         r_packet_formed <= (w_state_next == PUBLISH);
         r_we            <= 1'b0;
         case (r_state)
            IDLE: begin
               r_word_cnt <= '0;
               r_scan_cnt <= '0;
               r_wr_ptr   <= '0;
               r_hdr_idx  <= '0;
            end
            HEADER: begin
               r_we      <= 1'b1;
               r_wr_addr <= r_wr_ptr;
               r_wr_data <= w_hdr_word;
               r_wr_ptr  <= r_wr_ptr + 1'b1;
               r_hdr_idx <= w_hdr_done ? '0 : r_hdr_idx + 1'b1;
            end
            COLLECT: begin
               if (w_xfer) begin
                  r_we      <= 1'b1;
                  r_wr_addr <= r_wr_ptr;
                  r_wr_data <= sample_data;
                  if (w_scan_done) begin
                     r_word_cnt <= '0;
                     r_scan_seq <= r_scan_seq + 1'b1;
                     // Pointer folds back to 0 so it never leaves the packet area.
                     if (r_scan_cnt == LAST_SCAN) begin
                        r_scan_cnt <= '0;
                        r_wr_ptr   <= '0;
                     end else begin
                        r_scan_cnt <= r_scan_cnt + 1'b1;
                        r_wr_ptr   <= r_wr_ptr + 1'b1;
                     end
                  end else begin
                     r_word_cnt <= r_word_cnt + 1'b1;
                     r_wr_ptr   <= r_wr_ptr + 1'b1;
                  end
               end
            end
            WAIT_DONE: begin
               if (!eth_forming_packet) begin
                  r_seq_num <= r_seq_num + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign sample_ready  = r_ready;
   assign sram_wr_addr  = r_wr_addr;
   assign sram_wr_data  = r_wr_data;
   assign sram_we       = r_we;
   assign packet_formed = r_packet_formed;
   assign num_scans     = 32'(SCANS_PER_PACKET);
   assign seq_num       = r_seq_num;
   assign busy          = (r_state != IDLE);

endmodule
